// File: rtl/mips_reg_writeback.sv
// MIPS register-file write front end: merges the single-cycle pipeline
// result with buffered multicycle results onto one registered write port.
module mips_reg_writeback #(
    parameter int SEC_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pri_valid,
    input  logic [4:0]  pri_addr,
    input  logic [31:0] pri_data,
    output logic        pri_ready,
    input  logic        sec_valid,
    input  logic [4:0]  sec_addr,
    input  logic [31:0] sec_data,
    output logic        sec_ready,
    output logic        RegWrite,
    output logic [4:0]  WriteAddress,
    output logic [31:0] DataIn,
    output logic        sec_pending
);

    localparam int PW = (SEC_DEPTH > 1) ? $clog2(SEC_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve;

    logic [4:0]  mem_addr [SEC_DEPTH];
    logic [31:0] mem_data [SEC_DEPTH];

    logic        force_sec;
    logic        pri_sel;
    logic        push;
    logic        pop;
    logic        sel;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    assign sec_pending = (count != '0);
    assign force_sec   = sec_pending && (starve == SW'(STARVE_LIMIT));
    assign pri_ready   = rst && !force_sec;
    assign sec_ready   = rst && (count < CW'(SEC_DEPTH));

    // The FIFO head drains whenever the primary is idle or has starved it.
    assign pri_sel  = pri_ready && pri_valid;
    assign pop      = rst && sec_pending && (force_sec || !pri_valid);
    assign push     = sec_valid && sec_ready;
    assign sel      = pri_sel || pop;
    assign sel_addr = pri_sel ? pri_addr : mem_addr[rd_ptr];
    assign sel_data = pri_sel ? pri_data : mem_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= sec_addr;
            mem_data[wr_ptr] <= sec_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (pop || !sec_pending)
                starve <= '0;
            else if (pri_sel && starve != SW'(STARVE_LIMIT))
                starve <= starve + 1'b1;
        end
    end

    // Address 0 still updates the bus but never asserts the write strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWrite     <= 1'b0;
            WriteAddress <= '0;
            DataIn       <= '0;
        end else if (sel) begin
            RegWrite     <= (sel_addr != 5'd0);
            WriteAddress <= sel_addr;
            DataIn       <= sel_data;
        end else begin
            RegWrite     <= 1'b0;
        end
    end

endmodule

// File: doc/mips_reg_writeback.md
Name: mips_reg_writeback

Overview:
Write-side front end for the MIPS register file. It merges two writeback sources into the file's single write port (RegWrite / WriteAddress / DataIn):
- primary: the single-cycle ALU/load pipeline result;
- secondary: multicycle results such as mult/div completion.

The primary source normally wins arbitration. The secondary source is buffered in a small FIFO and protected against starvation. All register-file-side outputs are registered.

Parameters:
SEC_DEPTH, 2, secondary FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive primary wins tolerated while the FIFO is non-empty before the FIFO head is forced (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
pri_valid  input  1  primary writeback request
pri_addr  input  5  primary destination register
pri_data  input  32  primary write data
pri_ready  output  1  primary accepted this cycle (combinational)
sec_valid  input  1  secondary writeback request
sec_addr  input  5  secondary destination register
sec_data  input  32  secondary write data
sec_ready  output  1  secondary FIFO can accept (combinational)
RegWrite  output  1  register-file write enable (registered)
WriteAddress  output  5  register-file write address (registered)
DataIn  output  32  register-file write data (registered)
sec_pending  output  1  FIFO non-empty (registered state, combinational decode)

Behaviour:
- Handshakes:
  - A transfer occurs on a rising edge where valid && ready. No valid-to-ready dependency is required of the sources.
  - Once a source raises valid, it holds addr/data stable until the transfer.
- Reset (rst=0, asynchronous):
  - RegWrite=0, WriteAddress=0, DataIn=0.
  - FIFO empty (sec_pending=0), starve counter=0.
  - pri_ready=0 and sec_ready=0 while rst=0.
  - Reset mid-operation discards all buffered secondary entries; no write is issued for them.
- Secondary FIFO:
  - sec_ready = rst && (count < SEC_DEPTH). When full, sec_ready=0, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Strict order is preserved; pointers wrap modulo SEC_DEPTH.
- Arbitration, evaluated every cycle with rst=1:
  - force = sec_pending && (starve == STARVE_LIMIT).
  - If force: pop the FIFO head; pri_ready=0.
  - Else if pri_valid: pri_ready=1 and the primary is selected.
  - Else if sec_pending: pop the FIFO head; pri_ready=1, which is harmless because pri_valid=0.
  - Else: no selection; pri_ready=1.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) when the primary is selected while sec_pending=1.
  - Cleared on any FIFO pop, or whenever the FIFO is empty.
- Output stage, registered at the next rising edge:
  - WriteAddress/DataIn take the selected addr/data.
  - RegWrite=1 iff something was selected and addr!=0.
  - Addr 0 requests complete their handshake but produce RegWrite=0; WriteAddress/DataIn still update.
  - With no selection, RegWrite=0 and WriteAddress/DataIn hold their previous values.
- Latency:
  - Primary: 1 cycle from accept edge to RegWrite high.
  - Secondary: at least 2 cycles (push edge, then pop/issue edge).
  - Throughput: at most one register write per cycle.
- Write ordering:
  - Writes reach the file strictly in selection order; no merging of same-address writes.
  - Keeping same-register writes from both sources coherent is the hazard unit's responsibility, not this block's.
- A secondary request pushed in the cycle the FIFO is empty cannot be popped in that same cycle; there is no bypass.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 with pri_valid=1, sec_valid=1.
  - Required: RegWrite=0, WriteAddress=0, DataIn=0, both readys 0.
  - Stimulus: release rst.
  - Required: pri_ready=1 and sec_ready=1 on the first cycle.
- Primary stream:
  - Stimulus: pri (addr=5, data=0xDEADBEEF), then (addr=0, data=0x1234) on consecutive cycles.
  - Required: RegWrite=1/5/0xDEADBEEF one cycle later; the next cycle RegWrite=0, WriteAddress=0.
- Secondary fill and drain:
  - Stimulus: push 3 secondary writes (addr 8, 9, 10) with pri idle.
  - Required: sec_ready=0 after 2 un-popped entries only if pops are blocked. With pri idle, writes issue in order 8, 9, 10, and sec_pending drops after the last pop.
- Starvation guard:
  - Stimulus: pri_valid=1 continuously (addrs 1..), one secondary entry (addr 31, data 0xA5A5A5A5).
  - Required: 4 primary writes, then pri_ready=0 for one cycle and a write to 31 with 0xA5A5A5A5; primary resumes next.
- Full FIFO with simultaneous push/pop:
  - Stimulus: FIFO full, pri idle, sec_valid=1.
  - Required: sec_ready=0 that cycle, head pops; next cycle sec_ready=1 and push+pop coexist with count constant at 1..2.
- Async reset mid-stream:
  - Stimulus: drop rst between edges with 2 FIFO entries.
  - Required: RegWrite falls immediately, sec_pending=0, and the discarded entries never appear after release.
